mem_master: RTL

Single-port memory initiator for the smallCPU datapath. It accepts word read/write requests from the core over a valid/ready handshake and drives the memory block's `address`/`in`/`write_en` pins. Writes are sequenced so that address and data are stable around the rising edge of `write_en`. Read data is captured from the memory's combinational `out` and returned on a valid/ready response channel, with optional auto-incrementing read bursts.

---
 rtl/mem_master.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_master
//  Purpose  : Single-port memory initiator. Accepts word read/write requests
//             over a valid/ready handshake and drives a memory with a
//             combinational read port and a write_en rising-edge write.
//             Writes are sequenced setup/strobe/hold so that address and
//             data are stable around the rising edge of write_en. Reads
//             may be auto-incrementing bursts. Out-of-range addresses
//             (>= M) produce an error response without touching memory.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             req_*_i / req_ready_o - request channel (write, addr, wdata, len)
//             rsp_*_o / rsp_ready_i - response channel (data, last, err)
//             mem_*_o / mem_out_i   - memory address/in/write_en and out
//  Revision : 1.0 - initial release
// ============================================================================
module mem_master #(
    parameter int N = 16,
    parameter int M = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_write_i,
    input  logic [N-1:0] req_addr_i,
    input  logic [N-1:0] req_wdata_i,
    input  logic [7:0]   req_len_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [N-1:0] rsp_data_o,
    output logic         rsp_last_o,
    output logic         rsp_err_o,
    output logic [N-1:0] mem_address_o,
    output logic [N-1:0] mem_in_o,
    output logic         mem_write_en_o,
    input  logic [N-1:0] mem_out_i
);

    // One extra bit so that M == 2**N is representable; such an M makes
    // every address in range.
    localparam logic [N:0] C_M_LIMIT = (N+1)'(M);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_SETUP  = 3'd1,
        S_W_STROBE = 3'd2,
        S_W_HOLD   = 3'd3,
        S_R_ADDR   = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   addr_q, addr_d;
    logic [N-1:0]   wdata_q, wdata_d;
    logic [7:0]     remaining_q, remaining_d;
    logic [N-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_last_q, rsp_last_d;
    logic           rsp_err_q, rsp_err_d;

    logic [N-1:0]   w_next_addr;

    function automatic logic f_out_of_range(input logic [N-1:0] a);
        return ({1'b0, a} >= C_M_LIMIT);
    endfunction

    // Burst increment wraps modulo 2**N.
    assign w_next_addr = addr_q + N'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            remaining_q <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            remaining_q <= remaining_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        remaining_d    = remaining_q;
        rsp_data_d     = rsp_data_q;
        rsp_last_d     = rsp_last_q;
        rsp_err_d      = rsp_err_q;
        req_ready_o    = 1'b0;
        rsp_valid_o    = 1'b0;
        mem_address_o  = '0;
        mem_in_o       = '0;
        mem_write_en_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d      = req_addr_i;
                    wdata_d     = req_wdata_i;
                    remaining_d = (req_len_i == 8'd0) ? 8'd1 : req_len_i;
                    if (f_out_of_range(req_addr_i)) begin
                        rsp_data_d = '0;
                        rsp_last_d = 1'b1;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else if (req_write_i) begin
                        state_d = S_W_SETUP;
                    end else begin
                        state_d = S_R_ADDR;
                    end
                end
            end

            S_W_SETUP: begin
                mem_address_o = addr_q;
                mem_in_o      = wdata_q;
                state_d       = S_W_STROBE;
            end

            S_W_STROBE: begin
                mem_address_o  = addr_q;
                mem_in_o       = wdata_q;
                mem_write_en_o = 1'b1;
                state_d        = S_W_HOLD;
            end

            S_W_HOLD: begin
                mem_address_o = addr_q;
                mem_in_o      = wdata_q;
                rsp_data_d    = '0;
                rsp_last_d    = 1'b1;
                rsp_err_d     = 1'b0;
                state_d       = S_RESP;
            end

            S_R_ADDR: begin
                mem_address_o = addr_q;
                rsp_data_d    = mem_out_i;
                rsp_last_d    = (remaining_q == 8'd1);
                rsp_err_d     = 1'b0;
                state_d       = S_RESP;
            end

            S_RESP: begin
                rsp_valid_o   = 1'b1;
                // Keep the address steady while stalled so the memory sees
                // no activity under backpressure.
                mem_address_o = addr_q;
                if (rsp_ready_i) begin
                    if (rsp_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        remaining_d = remaining_q - 8'd1;
                        addr_d      = w_next_addr;
                        if (f_out_of_range(w_next_addr)) begin
                            // Burst ran off the end of memory: terminate early.
                            rsp_data_d = '0;
                            rsp_last_d = 1'b1;
                            rsp_err_d  = 1'b1;
                            state_d    = S_RESP;
                        end else begin
                            state_d = S_R_ADDR;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_last_o = rsp_last_q;
    assign rsp_err_o  = rsp_err_q;

endmodule
`default_nettype wire
